// File: rtl/bus_transfer_ctrl.sv
// Register-bus move sequencer: reads one source register over the shared bus
// (or takes an immediate), then issues a single destination write strobe.
module bus_transfer_ctrl #(
  parameter int DATA_W = 24,
  parameter int N_REG  = 8,
  localparam int SEL_W = $clog2(N_REG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_use_imm,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [SEL_W-1:0]  i_src_sel,
  input  logic [SEL_W-1:0]  i_dst_sel,
  input  logic [DATA_W-1:0] i_bus_in,
  output logic [N_REG-1:0]  o_read_bus,
  output logic [N_REG-1:0]  o_write_en,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, WRITE} state_t;

  localparam logic [N_REG-1:0] ONE_HOT_0 = N_REG'(1);

  state_t              r_state;
  state_t              w_next;
  logic [SEL_W-1:0]    r_src;
  logic [SEL_W-1:0]    r_dst;
  logic [DATA_W-1:0]   r_hold;
  logic                r_done;
  logic                r_err;
  logic                w_accept;
  logic                w_reject;
  logic [N_REG-1:0]    w_src_oh;
  logic [N_REG-1:0]    w_dst_oh;
  logic                w_src_ok;
  logic                w_dst_ok;

  // An out-of-range index shifts the single bit out of the vector, so an
  // all-zero decode doubles as the range check.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_src_oh = ONE_HOT_0 << i_src_sel;
    w_dst_oh = ONE_HOT_0 << i_dst_sel;
    w_src_ok = i_use_imm | (|w_src_oh);
    w_dst_ok = |w_dst_oh;
    case (r_state)
      IDLE: begin
        if (i_req) begin
          if (w_src_ok && w_dst_ok) begin
            w_accept = 1'b1;
            w_next   = i_use_imm ? WRITE : DRIVE;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      DRIVE:   w_next = LATCH;
      LATCH:   w_next = WRITE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_hold  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == WRITE);
      r_err   <= w_reject;
      if (w_accept) begin
        r_src <= i_src_sel;
        r_dst <= i_dst_sel;
        if (i_use_imm) r_hold <= i_imm;
      end
      // Capture at the end of the second drive cycle, after the bus has settled.
      if (r_state == LATCH) r_hold <= i_bus_in;
    end
  end

  assign o_read_bus = ((r_state == DRIVE) || (r_state == LATCH)) ? (ONE_HOT_0 << r_src) : '0;
  assign o_write_en = (r_state == WRITE) ? (ONE_HOT_0 << r_dst) : '0;
  assign o_data_out = r_hold;
  assign o_busy     = (r_state != IDLE);
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule
